// File: rtl/dot_accum_4bit.sv
// Purpose  : accumulate up to LEN unsigned 8-bit products into one saturating dot-product result.
// Latency  : result valid the cycle after the closing product is accepted; one bubble per result.
// Backpres.: in_ready is low while a result is held; result held stable until out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     product handshake; in_prod (8b) and in_last qualify with in_valid
//   out_valid/out_ready   result handshake; out_sum (ACC_W), out_cnt (CNT_W), out_ovf
module dot_accum_4bit #(
  parameter int ACC_W = 16,
  parameter int LEN   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_prod,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_sum,
  output logic [$clog2(LEN+1)-1:0]     out_cnt,
  output logic                         out_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_vld_q, out_vld_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  // One extra bit so the carry out of the add shows an overflow directly.
  logic [ACC_W:0]   nsum;
  logic [ACC_W-1:0] sat;
  logic             ovf_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             closing;
  logic             accept;

  assign in_ready = (state_q == S_ACC);
  assign accept   = in_valid & in_ready;

  assign nsum    = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_prod};
  // Once saturated, acc sits at max, so any later add carries out again and stays clamped.
  assign sat     = nsum[ACC_W] ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];
  assign ovf_n   = nsum[ACC_W] | ovf_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign closing = in_last | (cnt_q == CNT_W'(LEN - 1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_vld_d = out_vld_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          if (closing) begin
            out_sum_d = sat;
            out_cnt_d = cnt_inc;
            out_ovf_d = ovf_n;
            out_vld_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = S_DONE;
          end else begin
            acc_d = sat;
            cnt_d = cnt_inc;
            ovf_d = ovf_n;
          end
        end
      end
      default: begin
        // Result fields stay put after the handshake; only the valid drops.
        if (out_vld_q && out_ready) begin
          out_vld_d = 1'b0;
          state_d   = S_ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule
